// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem slave multiplexer: FSM states, page field
// position, default error read data and the slave-index width helper.
package iomem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int IOMEM_PAGE_MSB = 31;
  localparam int IOMEM_PAGE_LSB = 24;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Minimum of one bit so a single-slave build still has a legal index.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/iomem_slave_mux_if.sv
// picosoc iomem bus as seen between the CPU (master) and the slave mux (slave).
interface iomem_slave_mux_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_page_decode.sv
// Combinational page decode: address page -> slave hit and slave index.
// Pages below BASE_PAGE wrap to large offsets and therefore miss.
module iomem_page_decode #(
  parameter int         NUM_SLAVES = 4,
  parameter logic [7:0] BASE_PAGE  = 8'h03,
  parameter int         IDX_W      = 2
) (
  input  logic [7:0]       i_page,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [7:0] NS8 = 8'(NUM_SLAVES);

  logic [7:0] w_off;

  // Offset from the base page, compared unsigned against the slave count.
  always_comb begin
    w_off = i_page - BASE_PAGE;
    o_hit = (w_off < NS8);
    o_idx = w_off[IDX_W-1:0];
  end

endmodule

// File: rtl/iomem_slave_mux.sv
// Shares the picosoc iomem bus among NUM_SLAVES peripherals, one transaction at a time.
// Optional slave-hang abort is enabled by defining IOMEM_TIMEOUT_EN.
module iomem_slave_mux
  import iomem_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [7:0]  BASE_PAGE      = 8'h03,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  iomem_slave_mux_if.slave         cpu,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     err_unmapped,
  output logic                     err_timeout,
  output logic [31:0]              err_addr,
  input  logic                     err_clear
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam logic [NUM_SLAVES-1:0] ONE_HOT0 = NUM_SLAVES'(1);

  state_e                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_SLAVES-1:0] r_s_valid;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic                  r_err_unm;
  logic                  r_err_to;
  logic [31:0]           r_err_addr;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_sel_ready;
  logic [31:0]           w_sel_rdata;
  logic                  w_miss_set;
  logic                  w_to_set;

  iomem_page_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_PAGE  (BASE_PAGE),
    .IDX_W      (IDX_W)
  ) u_decode (
    .i_page (cpu.iomem_addr[IOMEM_PAGE_MSB:IOMEM_PAGE_LSB]),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Only the latched slave's ready/rdata can complete the transaction.
  always_comb begin
    w_sel_ready = s_ready[r_idx];
    w_sel_rdata = s_rdata[{r_idx, 5'd0} +: 32];
    w_miss_set  = (r_state == IDLE) && cpu.iomem_valid && !w_hit;
  end

`ifdef IOMEM_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_cnt;
  logic        w_expired;

  // Expiry only counts when the slave has not answered in the same cycle.
  always_comb begin
    w_expired = (r_cnt == TO_LIMIT);
    w_to_set  = (r_state == BUSY) && cpu.iomem_valid && !w_sel_ready && w_expired;
  end

  // Cycle counter for the current BUSY phase, cleared on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (r_state != BUSY) begin
      r_cnt <= 16'd0;
    end else if (!w_expired) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  logic w_unused_cfg;

  always_comb begin
    w_to_set     = 1'b0;
    w_unused_cfg = ^{16'(TIMEOUT_CYCLES), ERR_RDATA};
  end
`endif

  // Transaction sequencer with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= {IDX_W{1'b0}};
      r_s_valid <= {NUM_SLAVES{1'b0}};
      r_wstrb   <= 4'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_ready   <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu.iomem_valid && w_hit) begin
            r_idx     <= w_idx;
            r_addr    <= cpu.iomem_addr;
            r_wdata   <= cpu.iomem_wdata;
            r_wstrb   <= cpu.iomem_wstrb;
            r_s_valid <= ONE_HOT0 << w_idx;
            r_state   <= BUSY;
          end else if (cpu.iomem_valid) begin
            r_ready   <= 1'b1;
            r_rdata   <= 32'd0;
            r_state   <= RESP;
          end else begin
            r_state   <= IDLE;
          end
        end
        BUSY: begin
          if (!cpu.iomem_valid) begin
            r_s_valid <= {NUM_SLAVES{1'b0}};
            r_state   <= IDLE;
          end else if (w_sel_ready) begin
            r_rdata   <= w_sel_rdata;
            r_ready   <= 1'b1;
            r_s_valid <= {NUM_SLAVES{1'b0}};
            r_state   <= RESP;
          end else if (w_to_set) begin
`ifdef IOMEM_TIMEOUT_EN
            r_rdata   <= ERR_RDATA;
`endif
            r_ready   <= 1'b1;
            r_s_valid <= {NUM_SLAVES{1'b0}};
            r_state   <= RESP;
          end else begin
            r_state   <= BUSY;
          end
        end
        RESP: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready   <= 1'b0;
          r_s_valid <= {NUM_SLAVES{1'b0}};
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_unm  <= 1'b0;
      r_err_to   <= 1'b0;
      r_err_addr <= 32'd0;
    end else begin
      r_err_unm <= w_miss_set || (r_err_unm && !err_clear);
      r_err_to  <= w_to_set   || (r_err_to  && !err_clear);
      if (w_miss_set) begin
        r_err_addr <= cpu.iomem_addr;
      end else if (w_to_set) begin
        r_err_addr <= r_addr;
      end else begin
        r_err_addr <= r_err_addr;
      end
    end
  end

  assign cpu.iomem_ready = r_ready;
  assign cpu.iomem_rdata = r_rdata;
  assign s_valid         = r_s_valid;
  assign s_wstrb         = r_wstrb;
  assign s_addr          = r_addr;
  assign s_wdata         = r_wdata;
  assign err_unmapped    = r_err_unm;
  assign err_timeout     = r_err_to;
  assign err_addr        = r_err_addr;

endmodule

// File: tb/tb_iomem_slave_mux.sv
// Scoreboard bench for iomem_slave_mux: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever iomem_ready is seen.
module tb_iomem_slave_mux;
  localparam int NS = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        unm;
    logic        to;
    logic [31:0] eaddr;
    logic [31:0] cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NS-1:0]   s_valid;
  logic [NS-1:0]   s_ready = '0;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [NS*32-1:0] s_rdata = '0;
  logic            err_unmapped;
  logic            err_timeout;
  logic [31:0]     err_addr;
  logic            err_clear = 1'b0;
  logic [31:0]     cyc = 32'd0;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  iomem_slave_mux_if cpu ();

  iomem_slave_mux #(
    .NUM_SLAVES     (NS),
    .BASE_PAGE      (8'h03),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cpu.slave),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_wstrb      (s_wstrb),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_rdata      (s_rdata),
    .err_unmapped (err_unmapped),
    .err_timeout  (err_timeout),
    .err_addr     (err_addr),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && cpu.iomem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_rdata", cpu.iomem_rdata, e.rdata);
        chk("resp_err_unmapped", err_unmapped, e.unm);
        chk("resp_err_timeout", err_timeout, e.to);
        chk("resp_err_addr", err_addr, e.eaddr);
        chk("resp_s_valid_low", s_valid, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU transaction; rdy_c is the cycle the slave answers (-1 = never).
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int slave, input int rdy_c,
                         input logic [31:0] srdata, input logic [NS-1:0] exp_sv,
                         input int resp_c, input logic [31:0] exp_rd,
                         input logic exp_unm, input logic exp_to,
                         input logic [31:0] exp_ea, input logic clr);
    exp_t e;
    step();
    e.rdata = exp_rd; e.unm = exp_unm; e.to = exp_to; e.eaddr = exp_ea;
    e.cyc = cyc + 32'(resp_c);
    sb.push_back(e);
    cpu.iomem_valid = 1'b1;
    cpu.iomem_addr  = addr;
    cpu.iomem_wstrb = wstrb;
    cpu.iomem_wdata = wdata;
    err_clear       = clr;
    for (int c = 1; c <= resp_c; c++) begin
      step();
      err_clear = 1'b0;
      if (c == 1) begin
        chk("s_valid_c1", s_valid, exp_sv);
        if (exp_sv != '0) begin
          chk("s_addr", s_addr, addr);
          chk("s_wstrb", s_wstrb, wstrb);
          chk("s_wdata", s_wdata, wdata);
        end
      end
      if (c == rdy_c) begin
        s_ready[slave] = 1'b1;
        s_rdata[32*slave +: 32] = srdata;
      end else begin
        s_ready = '0;
      end
    end
    step();
    cpu.iomem_valid = 1'b0;
    s_ready = '0;
    step();
  endtask

  initial begin
    cpu.iomem_valid = 1'b0;
    cpu.iomem_addr  = 32'd0;
    cpu.iomem_wstrb = 4'd0;
    cpu.iomem_wdata = 32'd0;
    repeat (3) step();
    chk("rst_ready", cpu.iomem_ready, 1'b0);
    chk("rst_rdata", cpu.iomem_rdata, 32'd0);
    chk("rst_s_valid", s_valid, '0);
    chk("rst_s_bus", {s_wstrb, s_addr, s_wdata}, '0);
    chk("rst_flags", {err_unmapped, err_timeout}, 2'b00);
    chk("rst_err_addr", err_addr, 32'd0);
    reset = 1'b0;
    step();

    // Read slave 1, slave answers at cycle 3 -> ready at 4.
    run_txn(32'h0400_0010, 4'd0, 32'd0, 1, 3, 32'h1234_5678, 4'b0010,
            4, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 1'b0);
    // Write slave 0.
    run_txn(32'h0300_0000, 4'b0001, 32'h0000_00A5, 0, 2, 32'd0, 4'b0001,
            3, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    // Unmapped page 0x09.
    run_txn(32'h0900_0000, 4'd0, 32'd0, 0, -1, 32'd0, 4'b0000,
            1, 32'd0, 1'b1, 1'b0, 32'h0900_0000, 1'b0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clear_unmapped", err_unmapped, 1'b0);
    chk("clear_keeps_addr", err_addr, 32'h0900_0000);
    // Page below base wraps to a miss; clear in the same cycle loses.
    run_txn(32'h0200_0004, 4'b1111, 32'h5555_5555, 0, -1, 32'd0, 4'b0000,
            1, 32'd0, 1'b1, 1'b0, 32'h0200_0004, 1'b1);
    // Top mapped page, fastest slave.
    run_txn(32'h0600_0008, 4'd0, 32'd0, 3, 1, 32'hCAFE_F00D, 4'b1000,
            2, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0200_0004, 1'b0);
    // First page past the range.
    run_txn(32'h0700_0000, 4'd0, 32'd0, 0, -1, 32'd0, 4'b0000,
            1, 32'd0, 1'b1, 1'b0, 32'h0700_0000, 1'b0);

    // Reset while slave 3 is busy.
    step();
    cpu.iomem_valid = 1'b1;
    cpu.iomem_addr  = 32'h0600_0000;
    cpu.iomem_wstrb = 4'd0;
    step();
    chk("busy_s_valid", s_valid, 4'b1000);
    step();
    reset = 1'b1;
    cpu.iomem_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("reset_drops_s_valid", s_valid, '0);
    chk("reset_no_ready", cpu.iomem_ready, 1'b0);
    chk("reset_clears_flag", err_unmapped, 1'b0);
    step();
    run_txn(32'h0500_0020, 4'd0, 32'd0, 2, 2, 32'h0BAD_F00D, 4'b0100,
            3, 32'h0BAD_F00D, 1'b0, 1'b0, 32'd0, 1'b0);

`ifdef IOMEM_TIMEOUT_EN
    // Slave answers exactly on the expiry cycle: normal completion.
    run_txn(32'h0500_0040, 4'd0, 32'd0, 2, 9, 32'h7777_0001, 4'b0100,
            10, 32'h7777_0001, 1'b0, 1'b0, 32'd0, 1'b0);
    // Slave 2 never answers: abort 9 cycles after s_valid rises.
    run_txn(32'h0500_0044, 4'd0, 32'd0, 2, -1, 32'd0, 4'b0100,
            10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0500_0044, 1'b0);
`endif

    repeat (3) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
